// File: rtl/recon_edge_update.sv
// Reconstruction stage: adds residual rows to a latched predicted block, clamps,
// streams the rows out and then presents the edge samples for neighbouring blocks.
module recon_edge_update #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 16,
  parameter int RES_WIDTH  = 12
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       blk_valid,
  output logic                                       blk_ready,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] pred,
  input  logic                                       res_valid,
  output logic                                       res_ready,
  input  logic [RES_WIDTH*BLOCK_SIZE-1:0]            res_row,
  output logic                                       rec_valid,
  input  logic                                       rec_ready,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0]            rec_row,
  output logic [$clog2(BLOCK_SIZE)-1:0]              rec_row_idx,
  output logic                                       rec_last,
  output logic                                       edge_valid,
  input  logic                                       edge_ready,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0]            edge_bottom,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0]            edge_right,
  output logic [BIT_WIDTH-1:0]                       edge_corner,
  output logic [1:0]                                 fsm_state
);

  // Handshakes: a transfer happens on the rising clk edge where valid && ready;
  // a producer holds valid and data stable until that edge.
  localparam int IDX_W = $clog2(BLOCK_SIZE);
  localparam int SUM_W = ((BIT_WIDTH > RES_WIDTH) ? BIT_WIDTH : RES_WIDTH) + 2;
  localparam int ROW_W = BIT_WIDTH * BLOCK_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
  localparam logic signed [SUM_W-1:0] MAX_PIX = SUM_W'((1 << BIT_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, ROWS, DRAIN, EDGE} state_t;

  state_t           state;
  logic [IDX_W-1:0] row_cnt;
  logic [ROW_W-1:0] blk_rows [BLOCK_SIZE];
  logic [ROW_W-1:0] recon;
  logic             res_hs;

  function automatic logic [BIT_WIDTH-1:0] clamp_pix(input logic [BIT_WIDTH-1:0] p,
                                                     input logic [RES_WIDTH-1:0] r);
    logic signed [SUM_W-1:0] sum;
    sum = $signed({{(SUM_W-BIT_WIDTH){1'b0}}, p}) +
          $signed({{(SUM_W-RES_WIDTH){r[RES_WIDTH-1]}}, r});
    if (sum[SUM_W-1])      return '0;
    else if (sum > MAX_PIX) return '1;
    else                    return sum[BIT_WIDTH-1:0];
  endfunction

  assign blk_ready = (state == IDLE);
  assign res_ready = (state == ROWS) && (!rec_valid || rec_ready);
  assign res_hs    = res_valid && res_ready;
  assign fsm_state = state;

  always_comb begin
    recon = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      recon[i*BIT_WIDTH +: BIT_WIDTH] = clamp_pix(blk_rows[row_cnt][i*BIT_WIDTH +: BIT_WIDTH],
                                                  res_row[i*RES_WIDTH +: RES_WIDTH]);
    end
  end

  // Block storage carries no reset: it is only read after a fresh block is latched.
  always_ff @(posedge clk) begin
    if (blk_valid && blk_ready) begin
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        blk_rows[j] <= pred[j*ROW_W +: ROW_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_cnt     <= '0;
      rec_valid   <= 1'b0;
      rec_row     <= '0;
      rec_row_idx <= '0;
      rec_last    <= 1'b0;
      edge_valid  <= 1'b0;
      edge_bottom <= '0;
      edge_right  <= '0;
      edge_corner <= '0;
    end else begin
      if (rec_valid && rec_ready) rec_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (blk_valid) begin
            row_cnt <= '0;
            state   <= ROWS;
          end
        end
        ROWS: begin
          if (res_hs) begin
            rec_row     <= recon;
            rec_valid   <= 1'b1;
            rec_row_idx <= row_cnt;
            rec_last    <= (row_cnt == LAST_IDX);
            for (int j = 0; j < BLOCK_SIZE; j++) begin
              if (row_cnt == IDX_W'(j)) edge_right[j*BIT_WIDTH +: BIT_WIDTH] <= recon[ROW_W-1 -: BIT_WIDTH];
            end
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == LAST_IDX) begin
              edge_bottom <= recon;
              edge_corner <= recon[ROW_W-1 -: BIT_WIDTH];
              state       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Edges are published only once the last row has left the output register.
          if (rec_valid && rec_ready) begin
            edge_valid <= 1'b1;
            state      <= EDGE;
          end
        end
        EDGE: begin
          if (edge_ready) begin
            edge_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
